// File: rtl/wso_serial_capture_deserializer_if.sv
// Handshake/bus bundle for the WSO capture deserializer.
// Optional WSO_MASK_EN adds the per-bit compare mask.
interface wso_serial_capture_deserializer_if #(
    parameter int SIZE = 12,
    parameter int SKW  = 4,
    parameter int ERRW = 8
);
    logic            start;
    logic            shift_en;
    logic [SKW-1:0]  skip_cnt;
    logic            WSO;
    logic [SIZE-1:0] expected;
`ifdef WSO_MASK_EN
    logic [SIZE-1:0] mask;
`endif
    logic [SIZE-1:0] data_out;
    logic            done;
    logic            mismatch;
    logic            busy;
    logic [ERRW-1:0] err_count;

    modport master (
`ifdef WSO_MASK_EN
        output mask,
`endif
        output start,
        output shift_en,
        output skip_cnt,
        output WSO,
        output expected,
        input  data_out,
        input  done,
        input  mismatch,
        input  busy,
        input  err_count
    );

    modport slave (
`ifdef WSO_MASK_EN
        input  mask,
`endif
        input  start,
        input  shift_en,
        input  skip_cnt,
        input  WSO,
        input  expected,
        output data_out,
        output done,
        output mismatch,
        output busy,
        output err_count
    );
endinterface

// File: rtl/wso_serial_capture_deserializer.sv
// WSO capture deserializer: skips leading pipeline bits, rebuilds SIZE-bit
// words MSB-first, compares to expected and keeps a saturating error count.
// Build option WSO_MASK_EN: per-bit compare mask sampled at start.
module wso_serial_capture_deserializer #(
    parameter int SIZE     = 12,
    parameter int SKIP_MAX = 15,
    parameter int ERRW     = 8
) (
    input  logic WRCK,
    input  logic WRSTN,
    wso_serial_capture_deserializer_if.slave bus
);
    localparam int SKW = $clog2(SKIP_MAX + 1);
    localparam int BCW = $clog2(SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SKIP  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SKW-1:0]  skip_q, skip_d;
    logic [SKW-1:0]  skip_ld;
    logic [BCW-1:0]  bit_q, bit_d;
    logic [SIZE-1:0] sreg_q, sreg_d;
    logic [SIZE-1:0] word_nx;
    logic [SIZE-1:0] exp_q, exp_d;
    logic [SIZE-1:0] diff;
    logic [SIZE-1:0] data_q, data_d;
    logic            done_q, done_d;
    logic            mis_q, mis_d;
    logic [ERRW-1:0] err_q, err_d;
    logic            arm;
    logic            adv_skip;
    logic            adv_shift;
    logic            skip_last;
    logic            last_bit;
    int              skip_in;

`ifdef WSO_MASK_EN
    logic [SIZE-1:0] mask_q, mask_d;
`endif

    assign skip_in  = int'(bus.skip_cnt);
    assign skip_ld  = (skip_in > SKIP_MAX) ? SKW'(SKIP_MAX) : bus.skip_cnt;

    // start is honoured only when no frame is in flight
    assign arm = bus.start &
                 ((state_q == S_IDLE) | (state_q == S_DONE));

    assign adv_skip  = (state_q == S_SKIP) & bus.shift_en;
    assign adv_shift = (state_q == S_SHIFT) & bus.shift_en;
    assign skip_last = (skip_q == SKW'(1));
    assign last_bit  = (bit_q == BCW'(SIZE - 1));
    assign word_nx   = {sreg_q[SIZE-2:0], bus.WSO};

`ifdef WSO_MASK_EN
    assign diff = (word_nx ^ exp_q) & ~mask_q;
`else
    assign diff = word_nx ^ exp_q;
`endif

    // FSM next state: arm from IDLE/DONE, advance only on shift_en
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_SKIP:  if (adv_skip && skip_last) state_d = S_SHIFT;
            S_SHIFT: if (adv_shift && last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (arm) begin
            state_d = (skip_ld != '0) ? S_SKIP : S_SHIFT;
        end
    end

    // leading-bit skip counter, loaded at start
    always_comb begin
        skip_d = skip_q;
        if (arm) begin
            skip_d = skip_ld;
        end else if (adv_skip) begin
            skip_d = skip_q - 1'b1;
        end
    end

    // received-bit counter, wraps to 0 on the final bit
    always_comb begin
        bit_d = bit_q;
        if (arm) begin
            bit_d = '0;
        end else if (adv_shift) begin
            bit_d = last_bit ? '0 : bit_q + 1'b1;
        end
    end

    // shift register, first received bit ends up at the MSB
    always_comb begin
        sreg_d = sreg_q;
        if (adv_shift) begin
            sreg_d = word_nx;
        end
    end

    // reference word (and mask) captured with start
    always_comb begin
        exp_d = exp_q;
`ifdef WSO_MASK_EN
        mask_d = mask_q;
`endif
        if (arm) begin
            exp_d = bus.expected;
`ifdef WSO_MASK_EN
            mask_d = bus.mask;
`endif
        end
    end

    // word completion: publish data, pulse done, grade the word
    always_comb begin
        data_d = data_q;
        done_d = 1'b0;
        mis_d  = 1'b0;
        if (adv_shift && last_bit) begin
            data_d = word_nx;
            done_d = 1'b1;
            mis_d  = |diff;
        end
    end

    // sticky error count, saturating at all-ones
    always_comb begin
        err_d = err_q;
        if (done_d && mis_d && (err_q != {ERRW{1'b1}})) begin
            err_d = err_q + 1'b1;
        end
    end

    // FSM and counter registers
    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            state_q <= S_IDLE;
            skip_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            bit_q   <= bit_d;
        end
    end

    // datapath registers
    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            sreg_q <= '0;
            exp_q  <= '0;
`ifdef WSO_MASK_EN
            mask_q <= '0;
`endif
        end else begin
            sreg_q <= sreg_d;
            exp_q  <= exp_d;
`ifdef WSO_MASK_EN
            mask_q <= mask_d;
`endif
        end
    end

    // output registers
    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            data_q <= '0;
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            err_q  <= '0;
        end else begin
            data_q <= data_d;
            done_q <= done_d;
            mis_q  <= mis_d;
            err_q  <= err_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.done      = done_q;
    assign bus.mismatch  = mis_q;
    assign bus.busy      = (state_q == S_SKIP) | (state_q == S_SHIFT);
    assign bus.err_count = err_q;

endmodule
